// File: rtl/qu_accumulator.sv
// -----------------------------------------------------------------------------
// qu_accumulator
//
// Downstream stage of the quarter unit. Each accepted 16-bit product beat is
// split into lanes according to the job's fusion mode. Each lane field is
// sign- or zero-extended and added into a per-lane accumulator. After
// cfg_len beats the lane sums are offered on a valid/ready port.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   cfg_start           - one-cycle pulse, starts a job (honoured only when idle)
//   cfg_len             - number of beats to accumulate (0 = empty job)
//   cfg_mode            - 0: 4x4-bit lanes, 1: 2x8-bit lanes, 2/3: 1x16-bit lane
//   cfg_signed          - 1: sign-extend lane fields, 0: zero-extend
//   in_data/in_valid    - product beat stream
//   in_ready            - high in every accumulate cycle
//   acc_out             - lane sums, lane k at [k*LANE_W +: LANE_W]
//   ovf                 - sticky per-lane overflow for the current job
//   out_valid/out_ready - result handshake
//   busy                - high whenever a job is in progress
//
// LANE_W must be at least 16 so that a full 16-bit lane fits.
// -----------------------------------------------------------------------------
module qu_accumulator #(
    parameter int LANE_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [CNT_W-1:0]      cfg_len,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_signed,
    input  logic [15:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*LANE_W-1:0]   acc_out,
    output logic [3:0]            ovf,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       len_q, len_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [1:0]             mode_q, mode_d;
    logic                   signed_q, signed_d;
    logic [3:0][LANE_W-1:0] acc_q, acc_d;
    logic [3:0]             ovf_q, ovf_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;

    logic [LANE_W-1:0]      lane_sum [4];
    logic [3:0]             lane_ovf;
    logic [CNT_W-1:0]       count_inc;

    assign count_inc = count_q + 1'b1;

    // -------------------------------------------------------------------------
    // Per-lane extend + add. A lane that the active mode does not use sees a
    // zero operand, so it stays at zero and can never flag overflow.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [LANE_W-1:0] ext4;
            logic [LANE_W-1:0] ext8;
            logic [LANE_W-1:0] ext16;
            logic [LANE_W-1:0] operand;
            logic [LANE_W:0]   sum;

            assign ext4 = signed_q ? LANE_W'($signed(in_data[gi*4 +: 4]))
                                   : LANE_W'(in_data[gi*4 +: 4]);

            if (gi < 2) begin : g_has8
                assign ext8 = signed_q ? LANE_W'($signed(in_data[gi*8 +: 8]))
                                       : LANE_W'(in_data[gi*8 +: 8]);
            end else begin : g_no8
                assign ext8 = '0;
            end

            if (gi == 0) begin : g_has16
                assign ext16 = signed_q ? LANE_W'($signed(in_data))
                                        : LANE_W'(in_data);
            end else begin : g_no16
                assign ext16 = '0;
            end

            // Reserved mode 3 falls into the default arm, i.e. behaves as mode 2.
            always_comb begin
                operand = ext16;
                case (mode_q)
                    2'd0:    operand = ext4;
                    2'd1:    operand = ext8;
                    default: operand = ext16;
                endcase
            end

            assign sum = {1'b0, acc_q[gi]} + {1'b0, operand};
            assign lane_sum[gi] = sum[LANE_W-1:0];

            // Signed: operands agree in sign but the result does not.
            // Unsigned: carry out of the top lane bit.
            assign lane_ovf[gi] = signed_q
                ? ((acc_q[gi][LANE_W-1] == operand[LANE_W-1]) &&
                   (sum[LANE_W-1] != acc_q[gi][LANE_W-1]))
                : sum[LANE_W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        count_d  = count_q;
        mode_d   = mode_q;
        signed_d = signed_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    len_d    = cfg_len;
                    mode_d   = cfg_mode;
                    signed_d = cfg_signed;
                    count_d  = '0;
                    acc_d    = '0;
                    ovf_d    = '0;
                    // An empty job goes straight to presenting an all-zero result.
                    state_d  = (cfg_len == '0) ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid && in_ready_q) begin
                    for (int k = 0; k < 4; k++) begin
                        acc_d[k] = lane_sum[k];
                    end
                    ovf_d   = ovf_q | lane_ovf;
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state.
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            count_q     <= '0;
            mode_q      <= '0;
            signed_q    <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            signed_q    <= signed_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qu_accumulator.sv
// -----------------------------------------------------------------------------
// tb_qu_accumulator
//
// Directed stimulus for qu_accumulator. A behavioural model computes lane sums
// with plain integer arithmetic and is compared against the DUT on every
// falling edge; hand-computed literal results pin the model itself.
// -----------------------------------------------------------------------------
module tb_qu_accumulator;

    localparam int LANE_W = 16;
    localparam int CNT_W  = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cfg_start;
    logic [CNT_W-1:0]     cfg_len;
    logic [1:0]           cfg_mode;
    logic                 cfg_signed;
    logic [15:0]          in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*LANE_W-1:0]  acc_out;
    logic [3:0]           ovf;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;

    qu_accumulator #(.LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_len    (cfg_len),
        .cfg_mode   (cfg_mode),
        .cfg_signed (cfg_signed),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .acc_out    (acc_out),
        .ovf        (ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: job phase plus integer lane sums.
    // m_phase 0 = idle, 1 = collecting beats, 2 = result offered.
    // -------------------------------------------------------------------------
    int         m_phase;
    int         m_len;
    int         m_cnt;
    int         m_mode;
    bit         m_sgn;
    int         m_acc [4];
    logic [3:0] m_ovf;

    task automatic model_add(input logic [15:0] d);
        int w;
        int nl;
        int f;
        int old_v;
        int s;
        w  = (m_mode == 0) ? 4 : (m_mode == 1) ? 8 : 16;
        nl = 16 / w;
        for (int k = 0; k < nl; k++) begin
            f = (int'(d) >> (k * w)) & ((1 << w) - 1);
            if (m_sgn && f >= (1 << (w - 1))) f = f - (1 << w);
            old_v = m_acc[k];
            if (m_sgn) begin
                s = ((old_v >= 32768) ? old_v - 65536 : old_v) + f;
                if (s > 32767 || s < -32768) m_ovf[k] = 1'b1;
            end else begin
                if (old_v + f > 65535) m_ovf[k] = 1'b1;
            end
            m_acc[k] = (old_v + f) & 65535;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_len = 0; m_cnt = 0; m_mode = 0; m_sgn = 1'b0;
            for (int k = 0; k < 4; k++) m_acc[k] = 0;
            m_ovf = 4'b0;
        end else begin
            case (m_phase)
                0: if (cfg_start) begin
                    m_len = int'(cfg_len); m_mode = int'(cfg_mode); m_sgn = cfg_signed;
                    m_cnt = 0;
                    for (int k = 0; k < 4; k++) m_acc[k] = 0;
                    m_ovf = 4'b0;
                    m_phase = (cfg_len == 0) ? 2 : 1;
                end
                1: if (in_valid) begin
                    model_add(in_data);
                    m_cnt++;
                    if (m_cnt == m_len) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    function automatic logic [63:0] model_acc();
        logic [63:0] v;
        for (int k = 0; k < 4; k++) v[k*16 +: 16] = m_acc[k][15:0];
        return v;
    endfunction

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        check("in_ready", {63'd0, in_ready}, {63'd0, m_phase == 1});
        check("out_valid", {63'd0, out_valid}, {63'd0, m_phase == 2});
        check("busy", {63'd0, busy}, {63'd0, m_phase != 0});
        if (m_phase == 2) begin
            check("acc_out", acc_out, model_acc());
            check("ovf", {60'd0, ovf}, {60'd0, m_ovf});
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers; all inputs change 1 time unit after a rising edge.
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len, input int mode, input bit sgn);
        cfg_start = 1'b1; cfg_len = CNT_W'(len); cfg_mode = 2'(mode); cfg_signed = sgn;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            n_tests++; n_fail++;
            $display("FAIL out_valid_timeout: got 0, expected 1 within 20 cycles");
        end
    endtask

    task automatic finish_job(input string name, input logic [63:0] exp_acc, input logic [3:0] exp_ovf);
        wait_out();
        check({name, "_acc"}, acc_out, exp_acc);
        check({name, "_ovf"}, {60'd0, ovf}, {60'd0, exp_ovf});
        $display("[TB] job %s: acc_out=%h ovf=%b", name, acc_out, ovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
    endtask

    logic [63:0] held_acc;

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_len = '0; cfg_mode = '0; cfg_signed = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_acc", acc_out, 64'd0);
        check("rst_flags", {59'd0, ovf, in_ready, busy}, 64'd0);
        rst_n = 1'b1;
        tick();

        // in_valid while idle must not change anything.
        in_valid = 1'b1; in_data = 16'hFFFF;
        tick();
        in_valid = 1'b0;

        // Mode 0 unsigned, 3 beats; result one cycle after the last beat.
        start_job(3, 0, 1'b0);
        beat(16'h1234); beat(16'h1234); beat(16'h1234);
        check("m0u_latency", {63'd0, out_valid}, 64'd1);
        finish_job("m0u", {16'd3, 16'd6, 16'd9, 16'd12}, 4'b0000);

        start_job(2, 0, 1'b1);
        beat(16'hFFFF); beat(16'hFFFF);
        finish_job("m0s", {16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE}, 4'b0000);

        start_job(2, 1, 1'b1);
        beat(16'h807F); beat(16'h807F);
        finish_job("m1s", {16'h0000, 16'h0000, 16'hFF00, 16'h00FE}, 4'b0000);

        // Reserved mode 3 behaves as one 16-bit lane; unsigned carry out.
        start_job(2, 3, 1'b0);
        beat(16'hFFFF); beat(16'h0001);
        finish_job("m3u", 64'd0, 4'b0001);

        // Mode 2 signed overflow, then backpressure in DRAIN.
        start_job(2, 2, 1'b1);
        beat(16'h8000); beat(16'h8000);
        wait_out();
        held_acc = acc_out;
        check("m2s_acc", acc_out, 64'd0);
        check("m2s_ovf", {60'd0, ovf}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            cfg_start = (i == 2); cfg_len = 8'd5; cfg_mode = 2'd0;
            tick();
            cfg_start = 1'b0;
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_ready", {63'd0, in_ready}, 64'd0);
            check("bp_acc", acc_out, held_acc);
            $display("[TB] backpressure cycle %0d: out_valid=%b in_ready=%b", i, out_valid, in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_busy", {63'd0, busy}, 64'd0);
        check("bp_hold_acc", acc_out, held_acc);

        // Empty job: result offered one cycle after start.
        start_job(0, 0, 1'b0);
        check("len0_valid", {63'd0, out_valid}, 64'd1);
        finish_job("len0", 64'd0, 4'b0000);

        // Gaps between beats; only accepted beats count.
        start_job(4, 0, 1'b0);
        beat(16'h1111);
        tick();
        beat(16'h2222);
        tick(); tick();
        beat(16'h0F0F);
        check("gap_not_done", {63'd0, out_valid}, 64'd0);
        tick();
        beat(16'hF0F1);
        finish_job("gap", {16'd18, 16'd18, 16'd18, 16'd19}, 4'b0000);

        // Reset in the middle of a job.
        start_job(4, 0, 1'b0);
        beat(16'h1234); beat(16'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc", acc_out, 64'd0);
        check("mid_rst_flags", {58'd0, ovf, in_ready, busy, out_valid}, 64'd0);
        $display("[TB] reset mid-job: acc_out=%h busy=%b", acc_out, busy);
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst", {62'd0, busy, out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
